// File: rtl/mult_12x12.sv
// Signed 12x12 -> 24-bit multiplier: radix-4 Booth partial products, carry-save tree, ripple CPA.
// Define MULT12X12_PIPE_EN to add one output register stage with asynchronous clear on Hlt.
module mult_12x12 (
  input  logic        Clk,
  input  logic        Hlt,
  input  logic [11:0] Din,
  input  logic [11:0] Coeff,
  output logic [23:0] Product
);

  typedef logic [23:0] vec_t;

  typedef struct packed {
    vec_t s;
    vec_t c;
  } csa_t;

  // One 3:2 compressor per column; the column-23 carry falls off (result is mod 2^24).
  function automatic csa_t csa(input vec_t a, input vec_t b, input vec_t c);
    csa_t r;
    r.s = a ^ b ^ c;
    r.c = '0;
    for (int unsigned j = 0; j < 23; j++) begin
      r.c[j + 1] = (a[j] & b[j]) | (a[j] & c[j]) | (b[j] & c[j]);
    end
    return r;
  endfunction

  function automatic vec_t cpa(input vec_t a, input vec_t b);
    vec_t s;
    logic cy;
    s  = '0;
    cy = 1'b0;
    for (int unsigned j = 0; j < 24; j++) begin
      s[j] = a[j] ^ b[j] ^ cy;
      cy   = (a[j] & b[j]) | (a[j] & cy) | (b[j] & cy);
    end
    return s;
  endfunction

  logic [12:0] coeff_ext;
  logic [12:0] din_x1;
  logic [12:0] din_x2;
  logic [5:0]  neg;
  vec_t        rows [6];
  vec_t        neg_row;
  vec_t        result;

  assign coeff_ext = {Coeff, 1'b0};
  assign din_x1    = {Din[11], Din};
  assign din_x2    = {Din, 1'b0};

  for (genvar g = 0; g < 6; g++) begin : g_booth
    logic [2:0]  trip;
    logic        one;
    logic        two;
    logic [12:0] mag;
    logic [12:0] pp;
    logic        s;

    assign trip   = coeff_ext[2*g +: 3];
    assign one    = trip[1] ^ trip[0];
    assign two    = (trip[2] & ~trip[1] & ~trip[0]) | (~trip[2] & trip[1] & trip[0]);
    // Digit 111 is zero, so it must not inject a neg bit.
    assign neg[g] = trip[2] & ~(trip[1] & trip[0]);
    assign mag    = one ? din_x1 : (two ? din_x2 : '0);
    assign pp     = mag ^ {13{neg[g]}};
    assign s      = pp[12];

    // Sign encoding: row 0 carries {~s,s,s}, later rows {1,~s}; together they cancel every sign extension.
    if (g == 0) begin : g_first
      assign rows[g] = vec_t'({~s, s, s, pp[11:0]});
    end else begin : g_rest
      assign rows[g] = vec_t'({1'b1, ~s, pp[11:0]}) << (2 * g);
    end
  end

  always_comb begin
    neg_row = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      neg_row[2*i] = neg[i];
    end
  end

  csa_t l1a, l1b, l2, l3, l4;

  assign l1a    = csa(rows[0], rows[1], rows[2]);
  assign l1b    = csa(rows[3], rows[4], rows[5]);
  assign l2     = csa(l1a.s, l1a.c, l1b.s);
  assign l3     = csa(l2.s, l2.c, l1b.c);
  assign l4     = csa(l3.s, l3.c, neg_row);
  assign result = cpa(l4.s, l4.c);

`ifdef MULT12X12_PIPE_EN
  always_ff @(posedge Clk or posedge Hlt) begin
    if (Hlt) begin
      Product <= '0;
    end else begin
      Product <= result;
    end
  end
`else
  logic unused_clk_hlt;
  assign unused_clk_hlt = Clk ^ Hlt;
  assign Product        = result;
`endif

endmodule

// File: tb/tb_mult_12x12.sv
// Self-checking bench for mult_12x12; follows MULT12X12_PIPE_EN to match the build under test.
module tb_mult_12x12;

  logic        Clk;
  logic        Hlt;
  logic [11:0] Din;
  logic [11:0] Coeff;
  logic [23:0] Product;

  int n_total;
  int n_bad;

  mult_12x12 dut (
    .Clk     (Clk),
    .Hlt     (Hlt),
    .Din     (Din),
    .Coeff   (Coeff),
    .Product (Product)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [23:0] ref_prod(input logic [11:0] a, input logic [11:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[23:0];
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (Din=%h Coeff=%h)", tag, got, exp, Din, Coeff);
    end
  endtask

  // Drive operands away from the clock edge and check where the product is due.
  task automatic apply(input string tag, input logic [11:0] a, input logic [11:0] b);
    Din   = a;
    Coeff = b;
`ifdef MULT12X12_PIPE_EN
    @(posedge Clk);
    #1;
`else
    #1;
`endif
    check(tag, Product, ref_prod(a, b));
  endtask

  logic [11:0] corners [8];

  initial begin
    n_total = 0;
    n_bad   = 0;
    Hlt     = 1'b1;
    Din     = 12'd123;
    Coeff   = 12'hFFB;
    corners = '{12'h800, 12'h7FF, 12'h000, 12'h001, 12'hFFF, 12'h801, 12'h7FE, 12'h555};

`ifdef MULT12X12_PIPE_EN
    #2;
    check("reset_clear", Product, 24'h000000);
    @(posedge Clk);
    #1;
    check("reset_hold", Product, 24'h000000);
    Hlt = 1'b0;
`else
    #2;
    check("comb_in_reset", Product, 24'hFFFD99);
    Hlt = 1'b0;
    #1;
    check("comb_out_reset", Product, 24'hFFFD99);
`endif

    apply("max_pos", 12'h7FF, 12'h7FF);
    check("max_pos_const", Product, 24'h3FF001);
    apply("both_min", 12'h800, 12'h800);
    check("both_min_const", Product, 24'h400000);
    apply("mixed_ext", 12'h800, 12'h7FF);
    check("mixed_ext_const", Product, 24'hC00800);
    apply("edge_tap", 12'd100, 12'hFFD);
    check("edge_tap_const", Product, 24'hFFFED4);
    apply("neg_one_tap", 12'hFFF, 12'd173);
    check("neg_one_tap_const", Product, 24'hFFFF53);
    apply("zero_tap", 12'h000, 12'd173);
    check("zero_tap_const", Product, 24'h000000);

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        apply("corner", corners[i], corners[j]);
      end
    end

    for (int k = 0; k < 4000; k++) begin
      apply("random", 12'($urandom), 12'($urandom));
    end

    for (int k = 0; k < 500; k++) begin
      apply("rand_corner", corners[$urandom_range(0, 7)], 12'($urandom));
      apply("corner_rand", 12'($urandom), corners[$urandom_range(0, 7)]);
    end

`ifdef MULT12X12_PIPE_EN
    // Mid-cycle assert clears without waiting for an edge.
    Din   = 12'h123;
    Coeff = 12'h456;
    @(posedge Clk);
    #1;
    check("pre_halt", Product, ref_prod(12'h123, 12'h456));
    #2;
    Hlt = 1'b1;
    #1;
    check("halt_async", Product, 24'h000000);
    @(posedge Clk);
    #1;
    check("halt_held", Product, 24'h000000);
    Din   = 12'h7FF;
    Coeff = 12'h7FF;
    #1;
    Hlt = 1'b0;
    check("halt_release_pre", Product, 24'h000000);
    @(posedge Clk);
    #1;
    check("release_capture", Product, 24'h3FF001);
    for (int k = 0; k < 50; k++) begin
      apply("back_to_back", 12'($urandom), 12'($urandom));
    end
`else
    Din   = 12'd123;
    Coeff = 12'hFFB;
    for (int k = 0; k < 8; k++) begin
      Hlt = ~Hlt;
      #3;
      check("comb_ignores_clk_hlt", Product, 24'hFFFD99);
      @(posedge Clk);
      #1;
      check("comb_ignores_edge", Product, 24'hFFFD99);
    end
    Hlt = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
